// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard stall/flush sequencer.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    RUN,
    HOLD
  } state_e;

  // Architectural zero register; writes to it never produce a hazard.
  localparam int unsigned REG_ZERO = 0;

  // Number of bubble cycles a detected hazard requires.
  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// RAW hazard detection and stall/flush sequencing for the IF/ID stage of a 5-stage pipeline.
// Only the FSM state and the two performance counters are registered.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             forward_en,
  input  logic [REG_W-1:0] IF_ID_Regrs,
  input  logic [REG_W-1:0] IF_ID_Regrt,
  input  logic             IF_ID_Usesrt,
  input  logic [REG_W-1:0] ID_EX_Regdest,
  input  logic             ID_EX_Regwrite,
  input  logic             ID_EX_Memread,
  input  logic [REG_W-1:0] EX_MEM_Regrd,
  input  logic             EX_MEM_Regwrite,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import hazard_stall_ctrl_pkg::*;

  localparam logic [REG_W-1:0] RegZero = REG_W'(REG_ZERO);

  state_e     state_d, state_q;
  logic       match_ex, match_mem;
  logic [1:0] need;

  assign match_ex = ID_EX_Regwrite && (ID_EX_Regdest != RegZero) &&
                    ((ID_EX_Regdest == IF_ID_Regrs) ||
                     (IF_ID_Usesrt && (ID_EX_Regdest == IF_ID_Regrt)));

  assign match_mem = EX_MEM_Regwrite && (EX_MEM_Regrd != RegZero) &&
                     ((EX_MEM_Regrd == IF_ID_Regrs) ||
                      (IF_ID_Usesrt && (EX_MEM_Regrd == IF_ID_Regrt)));

  // With forwarding only a load result arrives too late; without it, WB writes before ID reads.
  always_comb begin
    need = NEED_NONE;
    if (forward_en) begin
      if (match_ex && ID_EX_Memread) begin
        need = NEED_ONE;
      end
    end else if (match_ex) begin
      need = NEED_TWO;
    end else if (match_mem) begin
      need = NEED_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     state_d = (need == NEED_TWO) ? HOLD : RUN;
      HOLD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Stall outputs are the default; a hazard always wins over a taken branch.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b1;
    if_id_flush  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (need == NEED_NONE) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            if_id_flush  = branch_taken;
          end
        end
        HOLD:    ;
        default: ;
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (id_ex_bubble && rst_n),
    .q     (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl against a cycle-count reference model.
module tb_hazard_stall_ctrl;

  localparam int SatMax = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        forward_en;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_dest, ex_mem_rd;
  logic        if_id_usesrt, id_ex_regwrite, id_ex_memread, ex_mem_regwrite, branch_taken;
  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model: remaining forced stall cycles plus integer counters; p_* is the post-edge value.
  int   m_rem, m_sc, m_fc, p_rem, p_sc, p_fc;
  logic e_pc, e_ifid, e_bub, e_fl;
  int   e_sc, e_fc;

  hazard_stall_ctrl #(
    .REG_W (5),
    .CNT_W (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .forward_en      (forward_en),
    .IF_ID_Regrs     (if_id_rs),
    .IF_ID_Regrt     (if_id_rt),
    .IF_ID_Usesrt    (if_id_usesrt),
    .ID_EX_Regdest   (id_ex_dest),
    .ID_EX_Regwrite  (id_ex_regwrite),
    .ID_EX_Memread   (id_ex_memread),
    .EX_MEM_Regrd    (ex_mem_rd),
    .EX_MEM_Regwrite (ex_mem_regwrite),
    .branch_taken    (branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    forward_en = 1'b1; if_id_rs = '0; if_id_rt = '0; if_id_usesrt = 1'b0;
    id_ex_dest = '0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
    ex_mem_rd = '0; ex_mem_regwrite = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic model_clear();
    m_rem = 0; m_sc = 0; m_fc = 0; p_rem = 0; p_sc = 0; p_fc = 0;
  endtask

  // Drive one cycle's inputs at the falling edge and compute the expected outputs.
  task automatic apply(input logic f, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic [4:0] exd, input logic exw, input logic exm,
                       input logic [4:0] md, input logic mw, input logic br);
    bit mex, mmem, stall;
    int need;
    @(negedge clk);
    m_rem = p_rem; m_sc = p_sc; m_fc = p_fc;
    forward_en = f; if_id_rs = rs; if_id_rt = rt; if_id_usesrt = ut;
    id_ex_dest = exd; id_ex_regwrite = exw; id_ex_memread = exm;
    ex_mem_rd = md; ex_mem_regwrite = mw; branch_taken = br;
    #1;
    mex  = exw && (exd != 0) && ((exd == rs) || (ut && (exd == rt)));
    mmem = mw && (md != 0) && ((md == rs) || (ut && (md == rt)));
    if (f) need = (mex && exm) ? 1 : 0;
    else   need = mex ? 2 : (mmem ? 1 : 0);
    stall  = (m_rem > 0) || (need > 0);
    e_pc   = !stall;
    e_ifid = !stall;
    e_bub  = stall;
    e_fl   = !stall && br;
    e_sc   = m_sc;
    e_fc   = m_fc;
    p_rem  = (m_rem > 0) ? m_rem - 1 : ((need > 0) ? need - 1 : 0);
    p_sc   = (stall && m_sc < SatMax) ? m_sc + 1 : m_sc;
    p_fc   = (e_fl && m_fc < SatMax) ? m_fc + 1 : m_fc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    forward_en = 1'b0; if_id_rs = 5'd3; id_ex_dest = 5'd3; id_ex_regwrite = 1'b1;
    branch_taken = 1'b1;
    model_clear();
    #2;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_outs: got %b want 0010",
               {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnts: got %h/%h want 0000/0000", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    apply(1, 8, 0, 0, 8, 1, 1, 0, 0, 0);
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble} !== 3'b001) begin
      errors++;
      $display("FAIL load_use_stall: got %b want 001", {pc_write, if_id_write, id_ex_bubble});
    end
    apply(1, 8, 0, 0, 0, 0, 0, 8, 1, 0);
    checks++;
    if ({pc_write, id_ex_bubble} !== 2'b10 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL load_use_release: got pc=%b bub=%b cnt=%0d want pc=1 bub=0 cnt=1",
               pc_write, id_ex_bubble, stall_cnt);
    end
  endtask

  task automatic test_raw_no_fwd();
    do_reset();
    apply(0, 1, 9, 1, 9, 1, 0, 0, 0, 0);
    checks++;
    if ({pc_write, id_ex_bubble} !== 2'b01) begin
      errors++;
      $display("FAIL raw_ex_stall1: got pc=%b bub=%b want pc=0 bub=1", pc_write, id_ex_bubble);
    end
    apply(0, 1, 9, 1, 0, 0, 0, 9, 0, 0);
    checks++;
    if ({pc_write, id_ex_bubble} !== {e_pc, e_bub} || id_ex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL raw_ex_hold: got pc=%b bub=%b want pc=0 bub=1", pc_write, id_ex_bubble);
    end
    apply(0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (id_ex_bubble !== 1'b0 || stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL raw_ex_done: got bub=%b cnt=%0d want bub=0 cnt=2", id_ex_bubble, stall_cnt);
    end
  endtask

  task automatic test_mem_raw();
    do_reset();
    apply(0, 10, 0, 0, 0, 0, 0, 10, 1, 0);
    checks++;
    if (id_ex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL raw_mem_stall: got bub=%b want 1", id_ex_bubble);
    end
    apply(0, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (id_ex_bubble !== 1'b0 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL raw_mem_done: got bub=%b cnt=%0d want bub=0 cnt=1", id_ex_bubble, stall_cnt);
    end
    apply(0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    checks++;
    if ({pc_write, id_ex_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL reg_zero: got pc=%b bub=%b want pc=1 bub=0", pc_write, id_ex_bubble);
    end
  endtask

  task automatic test_branch();
    do_reset();
    apply(1, 1, 2, 1, 3, 1, 1, 4, 1, 1);
    checks++;
    if (if_id_flush !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL branch_flush: got flush=%b pc=%b want flush=1 pc=1", if_id_flush, pc_write);
    end
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if_id_flush !== 1'b0 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL branch_cnt: got flush=%b cnt=%0d want flush=0 cnt=1", if_id_flush, flush_cnt);
    end
    apply(1, 8, 0, 0, 8, 1, 1, 0, 0, 1);
    checks++;
    if ({if_id_flush, id_ex_bubble} !== 2'b01) begin
      errors++;
      $display("FAIL branch_stall_wins: got flush=%b bub=%b want flush=0 bub=1",
               if_id_flush, id_ex_bubble);
    end
    apply(1, 8, 0, 0, 0, 0, 0, 8, 1, 1);
    checks++;
    if ({if_id_flush, id_ex_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL branch_after_stall: got flush=%b bub=%b want flush=1 bub=0",
               if_id_flush, id_ex_bubble);
    end
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (flush_cnt !== 16'd2 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL branch_totals: got flush=%0d stall=%0d want flush=2 stall=1",
               flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    apply(0, 9, 0, 0, 9, 1, 0, 0, 0, 0);
    apply(0, 9, 0, 0, 0, 0, 0, 9, 1, 1);
    checks++;
    if ({pc_write, id_ex_bubble, if_id_flush} !== 3'b010 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL hold_state: got pc=%b bub=%b fl=%b cnt=%0d want pc=0 bub=1 fl=0 cnt=1",
               pc_write, id_ex_bubble, if_id_flush, stall_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010 || stall_cnt !== 16'd0)
    begin
      errors++;
      $display("FAIL async_reset: got %b cnt=%0d want 0010 cnt=0",
               {pc_write, if_id_write, id_ex_bubble, if_id_flush}, stall_cnt);
    end
    model_clear();
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_run: got %b cnt=%0d want 110 cnt=0",
               {pc_write, if_id_write, id_ex_bubble}, stall_cnt);
    end
    apply(1, 5, 0, 0, 5, 1, 1, 0, 0, 0);
    checks++;
    if (id_ex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_fresh: got bub=%b want 1", id_ex_bubble);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 65534; i++) apply(1, 8, 0, 0, 8, 1, 1, 0, 0, 0);
    apply(1, 8, 0, 0, 8, 1, 1, 0, 0, 0);
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h want fffe", stall_cnt);
    end
    apply(1, 8, 0, 0, 8, 1, 1, 0, 0, 0);
    apply(1, 8, 0, 0, 8, 1, 1, 0, 0, 0);
    apply(1, 8, 0, 0, 8, 1, 1, 0, 0, 0);
    checks++;
    if (stall_cnt !== 16'hFFFF || stall_cnt !== 16'(e_sc)) begin
      errors++;
      $display("FAIL sat_hold: got %h want ffff", stall_cnt);
    end
  endtask

  task automatic test_random();
    logic f;
    do_reset();
    f = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) f = ~f;
      apply(f, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== {e_pc, e_ifid, e_bub, e_fl})
      begin
        errors++;
        $display("FAIL rand_outs[%0d]: got %b want %b", i,
                 {pc_write, if_id_write, id_ex_bubble, if_id_flush}, {e_pc, e_ifid, e_bub, e_fl});
      end
      checks++;
      if (stall_cnt !== 16'(e_sc) || flush_cnt !== 16'(e_fc)) begin
        errors++;
        $display("FAIL rand_cnts[%0d]: got %0d/%0d want %0d/%0d", i,
                 stall_cnt, flush_cnt, e_sc, e_fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_raw_no_fwd();
    test_mem_raw();
    test_branch();
    test_reset_in_hold();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
